// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Operands are captured on start; results are held until the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d, zero_q, zero_d;

  logic             d_bit, br_nx;
  logic [WIDTH-1:0] res_nx;

  // Single full-subtractor cell on the operand LSBs
  assign d_bit  = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nx  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_nx = {d_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = borrow_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_d = res_nx;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Result registers only move on the edge entering DONE
          cnt_d    = '0;
          diff_d   = res_nx;
          borrow_d = br_nx;
          zero_d   = (res_nx == '0);
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign busy       = (state_q == S_SHIFT);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign zero       = zero_q;

endmodule
